instruction_decode: RTL and testbench



---
 rtl/instruction_decode.sv | 161 ++++++++++++++++
 tb/tb_instruction_decode.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - MIPS ID stage: field split, register file, sign extension, control decode, ID/EX register
module instruction_decode #(
  parameter int len                  = 32,
  parameter int cantidad_registros   = 32,
  parameter int NB_address_registros = 5,
  parameter int NB_sign_extend       = 16,
  parameter int NB_INSTRUCCION       = 6,
  parameter int NB_ALU_CONTROL       = 4,
  parameter int NB_ALU_OP            = 2,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 3,
  parameter int NB_CTRL_EX           = 7
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [len-1:0]                  i_instruccion,
  input  logic [len-1:0]                  i_adder_pc,
  input  logic [len-1:0]                  i_write_data,
  input  logic [NB_address_registros-1:0] i_write_reg,
  input  logic                            i_RegWrite,
  output logic [len-1:0]                  o_adder_pc,
  output logic [NB_address_registros-1:0] o_rs,
  output logic [NB_address_registros-1:0] o_rt,
  output logic [NB_address_registros-1:0] o_rd,
  output logic [NB_address_registros-1:0] o_shamt,
  output logic [len-1:0]                  o_dato1,
  output logic [len-1:0]                  o_dato2,
  output logic [len-1:0]                  o_sign_extend,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
  output logic [NB_CTRL_EX-1:0]           o_ctrl_ex
);

  localparam logic [NB_INSTRUCCION-1:0] OP_RTYPE = 6'b000000;
  localparam logic [NB_INSTRUCCION-1:0] OP_LW    = 6'b100011;
  localparam logic [NB_INSTRUCCION-1:0] OP_SW    = 6'b101011;
  localparam logic [NB_INSTRUCCION-1:0] OP_BEQ   = 6'b000100;
  localparam int                        NB_EX_PAD = NB_CTRL_EX - NB_ALU_OP - 2;

  // The ALU control width is carried only so EX can share this parameter set.
  if (NB_ALU_CONTROL < NB_ALU_OP) begin : g_bad_alu_ctrl_width
    $error("NB_ALU_CONTROL must be at least NB_ALU_OP");
  end

  logic [len-1:0] regs_q [cantidad_registros];

  logic [NB_INSTRUCCION-1:0]       opcode;
  logic [NB_address_registros-1:0] rs, rt, rd, shamt;
  logic                            wr_en;
  logic [len-1:0]                  dato1_d, dato2_d, sext_d;

  assign opcode = i_instruccion[31:26];
  assign rs     = i_instruccion[25:21];
  assign rt     = i_instruccion[20:16];
  assign rd     = i_instruccion[15:11];
  assign shamt  = i_instruccion[10:6];
  assign wr_en  = i_RegWrite && (i_write_reg != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < cantidad_registros; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[i_write_reg] <= i_write_data;
    end
  end

  // Write-through so an instruction decoded in the WB cycle sees the new value.
  assign dato1_d = (rs == '0) ? '0 : ((wr_en && (i_write_reg == rs)) ? i_write_data : regs_q[rs]);
  assign dato2_d = (rt == '0) ? '0 : ((wr_en && (i_write_reg == rt)) ? i_write_data : regs_q[rt]);
  assign sext_d  = {{(len-NB_sign_extend){i_instruccion[NB_sign_extend-1]}},
                    i_instruccion[NB_sign_extend-1:0]};

  logic                 reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [NB_ALU_OP-1:0] alu_op;

  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        alu_op    = 2'b10;
        reg_write = 1'b1;
      end
      OP_LW: begin
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        alu_op = 2'b01;
        branch = 1'b1;
      end
      default: ;
    endcase
  end

  logic [len-1:0]                  adder_pc_q, dato1_q, dato2_q, sext_q;
  logic [NB_address_registros-1:0] rs_q, rt_q, rd_q, shamt_q;
  logic [NB_CTRL_WB-1:0]           ctrl_wb_q, ctrl_wb_d;
  logic [NB_CTRL_MEM-1:0]          ctrl_mem_q, ctrl_mem_d;
  logic [NB_CTRL_EX-1:0]           ctrl_ex_q, ctrl_ex_d;

  assign ctrl_wb_d  = {reg_write, mem_to_reg};
  assign ctrl_mem_d = {branch, mem_read, mem_write};
  assign ctrl_ex_d  = {reg_dst, alu_src, alu_op, {NB_EX_PAD{1'b0}}};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      adder_pc_q <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      shamt_q    <= '0;
      dato1_q    <= '0;
      dato2_q    <= '0;
      sext_q     <= '0;
      ctrl_wb_q  <= '0;
      ctrl_mem_q <= '0;
      ctrl_ex_q  <= '0;
    end else begin
      adder_pc_q <= i_adder_pc;
      rs_q       <= rs;
      rt_q       <= rt;
      rd_q       <= rd;
      shamt_q    <= shamt;
      dato1_q    <= dato1_d;
      dato2_q    <= dato2_d;
      sext_q     <= sext_d;
      ctrl_wb_q  <= ctrl_wb_d;
      ctrl_mem_q <= ctrl_mem_d;
      ctrl_ex_q  <= ctrl_ex_d;
    end
  end

  assign o_adder_pc    = adder_pc_q;
  assign o_rs          = rs_q;
  assign o_rt          = rt_q;
  assign o_rd          = rd_q;
  assign o_shamt       = shamt_q;
  assign o_dato1       = dato1_q;
  assign o_dato2       = dato2_q;
  assign o_sign_extend = sext_q;
  assign o_ctrl_wb     = ctrl_wb_q;
  assign o_ctrl_mem    = ctrl_mem_q;
  assign o_ctrl_ex     = ctrl_ex_q;

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed scoreboard bench for instruction_decode
module tb_instruction_decode;

  logic        clk;
  logic        rst;
  logic [31:0] instr, pc, wdata;
  logic [4:0]  wreg;
  logic        regwrite;

  logic [31:0] o_adder_pc, o_dato1, o_dato2, o_sign_extend;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [1:0]  o_ctrl_wb;
  logic [2:0]  o_ctrl_mem;
  logic [6:0]  o_ctrl_ex;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc, d1, d2, sext;
    logic [4:0]  rs, rt, rd, sh;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [6:0]  ex;
  } exp_t;

  exp_t sb[$];

  instruction_decode dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_instruccion (instr),
    .i_adder_pc    (pc),
    .i_write_data  (wdata),
    .i_write_reg   (wreg),
    .i_RegWrite    (regwrite),
    .o_adder_pc    (o_adder_pc),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_shamt       (o_shamt),
    .o_dato1       (o_dato1),
    .o_dato2       (o_dato2),
    .o_sign_extend (o_sign_extend),
    .o_ctrl_wb     (o_ctrl_wb),
    .o_ctrl_mem    (o_ctrl_mem),
    .o_ctrl_ex     (o_ctrl_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pc"},   o_adder_pc, 32'h0);
    check({tag, ".rs"},   {27'h0, o_rs}, 32'h0);
    check({tag, ".rt"},   {27'h0, o_rt}, 32'h0);
    check({tag, ".rd"},   {27'h0, o_rd}, 32'h0);
    check({tag, ".sh"},   {27'h0, o_shamt}, 32'h0);
    check({tag, ".d1"},   o_dato1, 32'h0);
    check({tag, ".d2"},   o_dato2, 32'h0);
    check({tag, ".sext"}, o_sign_extend, 32'h0);
    check({tag, ".wb"},   {30'h0, o_ctrl_wb}, 32'h0);
    check({tag, ".mem"},  {29'h0, o_ctrl_mem}, 32'h0);
    check({tag, ".ex"},   {25'h0, o_ctrl_ex}, 32'h0);
  endtask

  // Drive one decode cycle; expected result is queued now and compared after the edge.
  task automatic step(input string tag,
                      input logic [31:0] ins, input logic [31:0] pcv,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [31:0] e_d1, input logic [31:0] e_d2,
                      input logic [1:0] e_wb, input logic [2:0] e_mem, input logic [6:0] e_ex);
    exp_t e;
    exp_t got;
    instr    = ins;
    pc       = pcv;
    regwrite = we;
    wreg     = wr;
    wdata    = wd;
    e.pc   = pcv;
    e.rs   = ins[25:21];
    e.rt   = ins[20:16];
    e.rd   = ins[15:11];
    e.sh   = ins[10:6];
    e.sext = {{16{ins[15]}}, ins[15:0]};
    e.d1   = e_d1;
    e.d2   = e_d2;
    e.wb   = e_wb;
    e.mem  = e_mem;
    e.ex   = e_ex;
    sb.push_back(e);
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    checks++;
    assert (sb.size() == 1) else begin
      errors++;
      $error("FAIL %s.queue: observed=%0d expected=1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check({tag, ".pc"},   o_adder_pc, got.pc);
      check({tag, ".rs"},   {27'h0, o_rs}, {27'h0, got.rs});
      check({tag, ".rt"},   {27'h0, o_rt}, {27'h0, got.rt});
      check({tag, ".rd"},   {27'h0, o_rd}, {27'h0, got.rd});
      check({tag, ".sh"},   {27'h0, o_shamt}, {27'h0, got.sh});
      check({tag, ".d1"},   o_dato1, got.d1);
      check({tag, ".d2"},   o_dato2, got.d2);
      check({tag, ".sext"}, o_sign_extend, got.sext);
      check({tag, ".wb"},   {30'h0, o_ctrl_wb}, {30'h0, got.wb});
      check({tag, ".mem"},  {29'h0, o_ctrl_mem}, {29'h0, got.mem});
      check({tag, ".ex"},   {25'h0, o_ctrl_ex}, {25'h0, got.ex});
    end
  endtask

  initial begin
    rst = 1'b1; instr = '0; pc = '0; wdata = '0; wreg = '0; regwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    step("rtype0",  32'h0000_0000, 32'h0000_0000, 1'b0, 5'd0, 32'h0,   32'h0, 32'h0, 2'b10, 3'b000, 7'b1010000);
    step("wr_r1",   32'h3C00_0000, 32'h0000_0004, 1'b1, 5'd1, 32'h5,   32'h0, 32'h0, 2'b00, 3'b000, 7'b0000000);
    step("wr_r2",   32'h3C00_0000, 32'h0000_0008, 1'b1, 5'd2, 32'h7,   32'h0, 32'h0, 2'b00, 3'b000, 7'b0000000);
    step("add",     32'h0022_1820, 32'h0000_000C, 1'b0, 5'd0, 32'h0,   32'h5, 32'h7, 2'b10, 3'b000, 7'b1010000);
    step("lw",      32'h8C22_8020, 32'h0000_0010, 1'b0, 5'd0, 32'h0,   32'h5, 32'h7, 2'b11, 3'b010, 7'b0100000);
    step("sw",      32'hAC22_0000, 32'h0000_0014, 1'b0, 5'd0, 32'h0,   32'h5, 32'h7, 2'b00, 3'b001, 7'b0100000);
    step("beq",     32'h1042_0010, 32'h0000_0018, 1'b0, 5'd0, 32'h0,   32'h7, 32'h7, 2'b00, 3'b100, 7'b0001000);
    step("wr_r0",   32'h3C00_0000, 32'h0000_001C, 1'b1, 5'd0, 32'hDEAD, 32'h0, 32'h0, 2'b00, 3'b000, 7'b0000000);
    step("rd_r0",   32'h0000_0000, 32'h0000_0020, 1'b0, 5'd0, 32'h0,   32'h0, 32'h0, 2'b10, 3'b000, 7'b1010000);
    step("bypass",  32'h0081_0000, 32'h0000_0024, 1'b1, 5'd4, 32'h9,   32'h9, 32'h5, 2'b10, 3'b000, 7'b1010000);
    step("rd_r4",   32'h0004_2000, 32'h0000_0028, 1'b0, 5'd0, 32'h0,   32'h0, 32'h9, 2'b10, 3'b000, 7'b1010000);
    step("rt_byp",  32'h0022_1820, 32'h0000_002C, 1'b1, 5'd2, 32'h33,  32'h5, 32'h33, 2'b10, 3'b000, 7'b1010000);
    step("unknown", 32'h3C00_0000, 32'h0000_0104, 1'b0, 5'd0, 32'h0,   32'h0, 32'h0, 2'b00, 3'b000, 7'b0000000);

    // Async reset mid-cycle must clear outputs without a clock edge.
    instr = 32'h8C22_8020;
    pc    = 32'h0000_0200;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", 32'h0022_1820, 32'h0000_0300, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 2'b10, 3'b000, 7'b1010000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
